// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light monitor.
//   - Lamp encodings (one-hot, bit 0 = Green, bit 1 = Yellow, bit 2 = Red).
//   - Fault codes reported on fault_code.
//   - Monitor FSM state type.
//   - Small helpers: one-hot test, illegal colour step test, dwell limit lookup.
package traffic_pkg;

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] OFF    = 3'b000;

    typedef enum logic [2:0] {
        NONE     = 3'd0,
        ILLEGAL  = 3'd1,
        CONFLICT = 3'd2,
        DWELL    = 3'd3,
        SEQUENCE = 3'd4
    } fault_code_t;

    typedef enum logic {
        NORMAL = 1'b0,
        FLASH  = 1'b1
    } state_t;

    function automatic logic is_onehot(input logic [2:0] v);
        return (v == GREEN) || (v == YELLOW) || (v == RED);
    endfunction

    // Skipping a colour in the G -> Y -> R -> G cycle is a sequence error.
    function automatic logic bad_step(input logic [2:0] prev, input logic [2:0] cur);
        return ((prev == GREEN)  && (cur == RED))    ||
               ((prev == YELLOW) && (cur == GREEN))  ||
               ((prev == RED)    && (cur == YELLOW));
    endfunction

    // Red has no dwell limit; 15 can never be exceeded by a saturating 4-bit count.
    function automatic logic [3:0] dwell_limit(input logic [2:0] colour,
                                               input int         max_green,
                                               input int         max_yellow);
        if (colour == GREEN)
            return 4'(max_green);
        else if (colour == YELLOW)
            return 4'(max_yellow);
        else
            return 4'd15;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Counts consecutive cycles one direction shows the same colour and flags
// when a Green or Yellow run would exceed its limit.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clear        zero the count and forget the last colour
//   colour [3]   lamp command sampled this cycle
//   limit  [4]   maximum legal run length for the current colour
//   over_limit   current sample makes the run longer than limit
module dwell_counter
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [2:0] colour,
    input  logic [3:0] limit,
    output logic       over_limit
);

    logic [3:0] count_reg;
    logic [2:0] colour_reg;
    logic [4:0] count_now;
    logic [3:0] count_next;

    // Run length including the current sample; a zero count means no history,
    // so the first sample of any colour starts a fresh run at 1.
    always_comb begin
        count_now = 5'd1;
        if ((colour == colour_reg) && (count_reg != 4'd0))
            count_now = {1'b0, count_reg} + 5'd1;
        count_next = count_now[4] ? 4'd15 : count_now[3:0];
        over_limit = ((colour == GREEN) || (colour == YELLOW)) &&
                     (count_now > {1'b0, limit});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg  <= 4'd0;
            colour_reg <= OFF;
        end else if (clear) begin
            count_reg  <= 4'd0;
            colour_reg <= OFF;
        end else begin
            count_reg  <= count_next;
            colour_reg <= colour;
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Safety monitor between a traffic light controller and the lamp drivers.
// In NORMAL the lamp commands pass through with one cycle of latency. Any
// illegal, conflicting, over-long or out-of-sequence command latches a fault
// and switches both directions to flashing Red until a clear request arrives
// together with a safe command pair.
// Optional feature: define MONITOR_DWELL_CHECK_EN to build the per-direction
// dwell counters and report code 3 (DWELL); without it MAX_GREEN/MAX_YELLOW
// are unused.
// Parameters:
//   MAX_GREEN   longest legal Green run (1..14)
//   MAX_YELLOW  longest legal Yellow run (1..14)
//   FLASH_DIV   cycles per half-period of the fault flash (1..15)
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   light_a, light_b  controller lamp commands (001 G, 010 Y, 100 R)
//   clr_fault         request to leave the fault state
//   lamp_a, lamp_b    registered lamp drive
//   fault             fault latched (FLASH state)
//   fault_code        cause of the latched fault
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int MAX_GREEN  = 6,
    parameter int MAX_YELLOW = 2,
    parameter int FLASH_DIV  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_a,
    input  logic [2:0] light_b,
    input  logic       clr_fault,
    output logic [2:0] lamp_a,
    output logic [2:0] lamp_b,
    output logic       fault,
    output logic [2:0] fault_code
);

    state_t      state_reg,   state_next;
    fault_code_t code_reg,    code_next;
    logic [2:0]  lamp_a_reg,  lamp_a_next;
    logic [2:0]  lamp_b_reg,  lamp_b_next;
    logic [2:0]  prev_a_reg,  prev_a_next;
    logic [2:0]  prev_b_reg,  prev_b_next;
    logic        hist_reg,    hist_next;
    logic [3:0]  div_reg,     div_next;
    logic        phase_reg,   phase_next;

    logic        illegal;
    logic        conflict;
    logic        dwell_hit;
    logic        seq_hit;
    logic        clear_ok;
    fault_code_t detected;

    // ------------------------------------------------------------------
    // Dwell checking
    // ------------------------------------------------------------------
`ifdef MONITOR_DWELL_CHECK_EN
    logic [2:0] dir_light [2];
    logic [1:0] dir_over;

    assign dir_light[0] = light_a;
    assign dir_light[1] = light_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dwell
            dwell_counter u_dwell (
                .clk        (clk),
                .rst        (rst),
                // Counters only run in NORMAL, so leaving FLASH starts fresh runs.
                .clear      (state_reg == FLASH),
                .colour     (dir_light[gi]),
                .limit      (dwell_limit(dir_light[gi], MAX_GREEN, MAX_YELLOW)),
                .over_limit (dir_over[gi])
            );
        end
    endgenerate

    assign dwell_hit = |dir_over;
`else
    assign dwell_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Fault detection on the current sample
    // ------------------------------------------------------------------
    always_comb begin
        illegal  = !is_onehot(light_a) || !is_onehot(light_b);
        conflict = !illegal && (light_a != RED) && (light_b != RED);
        seq_hit  = hist_reg && (bad_step(prev_a_reg, light_a) ||
                                bad_step(prev_b_reg, light_b));
        clear_ok = clr_fault && !illegal && !conflict;

        if (illegal)
            detected = ILLEGAL;
        else if (conflict)
            detected = CONFLICT;
        else if (dwell_hit)
            detected = DWELL;
        else if (seq_hit)
            detected = SEQUENCE;
        else
            detected = NONE;
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        code_next   = code_reg;
        lamp_a_next = lamp_a_reg;
        lamp_b_next = lamp_b_reg;
        prev_a_next = prev_a_reg;
        prev_b_next = prev_b_reg;
        hist_next   = hist_reg;
        div_next    = div_reg;
        phase_next  = phase_reg;

        case (state_reg)
            NORMAL: begin
                if (detected != NONE) begin
                    // The offending sample is replaced by the first Red phase.
                    state_next  = FLASH;
                    code_next   = detected;
                    lamp_a_next = RED;
                    lamp_b_next = RED;
                    hist_next   = 1'b0;
                    div_next    = 4'd0;
                    phase_next  = 1'b0;
                end else begin
                    lamp_a_next = light_a;
                    lamp_b_next = light_b;
                    prev_a_next = light_a;
                    prev_b_next = light_b;
                    hist_next   = 1'b1;
                end
            end

            FLASH: begin
                hist_next = 1'b0;
                if (clear_ok) begin
                    // The clearing sample is safe, so it drives the lamps
                    // directly; sequence history restarts from the next sample.
                    state_next  = NORMAL;
                    code_next   = NONE;
                    lamp_a_next = light_a;
                    lamp_b_next = light_b;
                    div_next    = 4'd0;
                    phase_next  = 1'b0;
                end else if (div_reg == 4'(FLASH_DIV - 1)) begin
                    div_next    = 4'd0;
                    phase_next  = !phase_reg;
                    // New phase 1 is dark, phase 0 is Red.
                    lamp_a_next = phase_reg ? RED : OFF;
                    lamp_b_next = phase_reg ? RED : OFF;
                end else begin
                    div_next    = div_reg + 4'd1;
                end
            end

            default: begin
                state_next = NORMAL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= NORMAL;
            code_reg   <= NONE;
            lamp_a_reg <= RED;
            lamp_b_reg <= RED;
            prev_a_reg <= OFF;
            prev_b_reg <= OFF;
            hist_reg   <= 1'b0;
            div_reg    <= 4'd0;
            phase_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            code_reg   <= code_next;
            lamp_a_reg <= lamp_a_next;
            lamp_b_reg <= lamp_b_next;
            prev_a_reg <= prev_a_next;
            prev_b_reg <= prev_b_next;
            hist_reg   <= hist_next;
            div_reg    <= div_next;
            phase_reg  <= phase_next;
        end
    end

    assign lamp_a     = lamp_a_reg;
    assign lamp_b     = lamp_b_reg;
    assign fault      = (state_reg == FLASH);
    assign fault_code = code_reg;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed, table-driven bench for traffic_light_monitor (default parameters).
// Each vector is driven on the falling edge, sampled on the rising edge and
// the registered outputs are compared 1 time unit after that rising edge.
module tb_traffic_light_monitor;
    import traffic_pkg::*;

    logic       clk;
    logic       rst;
    logic [2:0] light_a;
    logic [2:0] light_b;
    logic       clr_fault;
    logic [2:0] lamp_a;
    logic [2:0] lamp_b;
    logic       fault;
    logic [2:0] fault_code;

    int checks;
    int failures;

    typedef struct {
        logic [2:0] va;
        logic [2:0] vb;
        logic       vclr;
        logic [2:0] ea;
        logic [2:0] eb;
        logic       ef;
        logic [2:0] ec;
        logic       chk_lamps;
    } vec_t;

    vec_t vecs[$];

    traffic_light_monitor #(
        .MAX_GREEN  (6),
        .MAX_YELLOW (2),
        .FLASH_DIV  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .light_a    (light_a),
        .light_b    (light_b),
        .clr_fault  (clr_fault),
        .lamp_a     (lamp_a),
        .lamp_b     (lamp_b),
        .fault      (fault),
        .fault_code (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic [2:0] va, input logic [2:0] vb, input logic vclr,
                       input logic [2:0] ea, input logic [2:0] eb,
                       input logic ef, input logic [2:0] ec, input logic chk_lamps);
        vec_t v;
        v.va = va; v.vb = vb; v.vclr = vclr;
        v.ea = ea; v.eb = eb; v.ef = ef; v.ec = ec; v.chk_lamps = chk_lamps;
        vecs.push_back(v);
    endtask

    task automatic check3(input string nm, input int idx,
                          input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%b required=%b", nm, idx, act, exp);
        end
    endtask

    task automatic check_outputs(input int idx, input logic [2:0] ea, input logic [2:0] eb,
                                 input logic ef, input logic [2:0] ec, input logic chk_lamps);
        if (chk_lamps) begin
            check3("lamp_a", idx, lamp_a, ea);
            check3("lamp_b", idx, lamp_b, eb);
        end
        check3("fault", idx, {2'b00, fault}, {2'b00, ef});
        check3("fault_code", idx, fault_code, ec);
        $display("vec %0d: a=%b b=%b clr=%b -> lamp_a=%b lamp_b=%b fault=%b code=%0d",
                 idx, light_a, light_b, clr_fault, lamp_a, lamp_b, fault, fault_code);
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        light_a   = v.va;
        light_b   = v.vb;
        clr_fault = v.vclr;
        @(posedge clk);
        #1;
        check_outputs(idx, v.ea, v.eb, v.ef, v.ec, v.chk_lamps);
    endtask

    initial begin
        logic [2:0] a;
        logic [2:0] b;
        checks    = 0;
        failures  = 0;

        // ---------------- vector table ----------------
        // Normal drive: A = G x5, Y, R x6; B complementary; three rounds.
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 12; i++) begin
                a = (i < 5) ? GREEN : ((i == 5) ? YELLOW : RED);
                b = (i < 6) ? RED   : ((i < 11) ? GREEN  : YELLOW);
                add(a, b, 1'b0, a, b, 1'b0, 3'd0, 1'b1);
            end
        end
        // Conflict, then flashing: Red, Red, dark, dark.
        add(GREEN,  GREEN, 1'b0, RED, RED, 1'b1, 3'd2, 1'b1);
        add(RED,    RED,   1'b0, RED, RED, 1'b1, 3'd2, 1'b1);
        add(3'b011, RED,   1'b0, OFF, OFF, 1'b1, 3'd2, 1'b1); // new fault keeps code 2
        add(3'b110, RED,   1'b1, OFF, OFF, 1'b1, 3'd2, 1'b1); // clear with illegal A ignored
        add(RED,    GREEN, 1'b1, OFF, OFF, 1'b0, 3'd0, 1'b0); // accepted clear
        // Sequence checking
        add(RED,    YELLOW, 1'b0, RED,   YELLOW, 1'b0, 3'd0, 1'b1); // B G->Y
        add(RED,    RED,    1'b1, RED,   RED,    1'b0, 3'd0, 1'b1); // clr in NORMAL: no effect
        add(GREEN,  RED,    1'b0, GREEN, RED,    1'b0, 3'd0, 1'b1); // A R->G
        add(RED,    RED,    1'b0, RED,   RED,    1'b1, 3'd4, 1'b1); // A G->R
        add(RED,    GREEN,  1'b1, OFF,   OFF,    1'b0, 3'd0, 1'b0);
        // Priority: illegal A
        add(RED,    GREEN,  1'b0, RED,   GREEN,  1'b0, 3'd0, 1'b1);
        add(3'b011, GREEN,  1'b0, RED,   RED,    1'b1, 3'd1, 1'b1);
        add(RED,    RED,    1'b1, OFF,   OFF,    1'b0, 3'd0, 1'b0);
        // Dwell: A Green for 7 cycles
        for (int i = 0; i < 6; i++)
            add(GREEN, RED, 1'b0, GREEN, RED, 1'b0, 3'd0, 1'b1);
`ifdef MONITOR_DWELL_CHECK_EN
        add(GREEN,  RED, 1'b0, RED, RED, 1'b1, 3'd3, 1'b1);
        add(YELLOW, RED, 1'b0, RED, RED, 1'b1, 3'd3, 1'b1);
`else
        add(GREEN,  RED, 1'b0, GREEN,  RED, 1'b0, 3'd0, 1'b1);
        add(YELLOW, RED, 1'b0, YELLOW, RED, 1'b0, 3'd0, 1'b1);
`endif
        add(RED,    RED,   1'b1, OFF, OFF, 1'b0, 3'd0, 1'b0);
        // Conflict again to enter FLASH before the reset sequence.
        add(GREEN,  GREEN, 1'b0, RED, RED, 1'b1, 3'd2, 1'b1);

        // ---------------- reset state ----------------
        rst       = 1'b1;
        light_a   = RED;
        light_b   = RED;
        clr_fault = 1'b0;
        #1;
        check_outputs(-1, RED, RED, 1'b0, 3'd0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table ----------------
        foreach (vecs[i])
            apply(i, vecs[i]);

        // ---------------- reset mid-FLASH ----------------
        @(negedge clk);
        light_a = RED;
        light_b = RED;
        rst     = 1'b1;
        #1;
        check_outputs(-2, RED, RED, 1'b0, 3'd0, 1'b1);
        @(posedge clk);
        #1;
        check_outputs(-3, RED, RED, 1'b0, 3'd0, 1'b1);
        @(negedge clk);
        rst     = 1'b0;
        light_a = RED;
        light_b = GREEN;
        @(posedge clk);
        #1;
        check_outputs(-4, RED, GREEN, 1'b0, 3'd0, 1'b1);
        @(negedge clk);
        light_b = YELLOW;
        @(posedge clk);
        #1;
        check_outputs(-5, RED, YELLOW, 1'b0, 3'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
